pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage SimpleCPU pipe (IF ID EX MEM WB).
//  - Shadows the instruction bytes held in EX, MEM and WB.
//  - Decides stall, bubble, flush and EX-operand forwarding each cycle.
//  - Drives the ProgramCounter we, the IF/ID enable/flush, the ID/EX NOP insert
//    and the two Mux_3_to_1 operand selects.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 58 +++++
 rtl/pipe_hazard_ctrl_if.sv | 21 ++
 rtl/pipe_hazard_ctrl_dec.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// SimpleCPU ISA constants and decode helpers shared by the hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_AND     = 4'h3;
  localparam logic [3:0] OP_OR      = 4'h4;
  localparam logic [3:0] OP_XOR     = 4'h5;
  localparam logic [3:0] OP_OUT     = 4'h6;
  localparam logic [3:0] OP_IN      = 4'h7;
  localparam logic [3:0] OP_MOV     = 4'h8;
  localparam logic [3:0] OP_LOAD    = 4'hD;
  localparam logic [3:0] OP_STORE   = 4'hE;
  localparam logic [3:0] OP_LOADIMM = 4'hF;

  localparam logic [7:0] ISA_NOP = 8'h00;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } fwd_sel_e;

  function automatic logic [3:0] op_of(input logic [7:0] ins);
    return ins[7:4];
  endfunction

  function automatic logic [1:0] ra_of(input logic [7:0] ins);
    return ins[3:2];
  endfunction

  function automatic logic [1:0] rb_of(input logic [7:0] ins);
    return ins[1:0];
  endfunction

  // True when an instruction with the given read flags sources register r.
  function automatic logic uses_reg(input logic rd_a, input logic rd_b,
                                    input logic [7:0] ins, input logic [1:0] r);
    return (rd_a && (ra_of(ins) == r)) || (rd_b && (rb_of(ins) == r));
  endfunction

  // Youngest producer wins; a load in MEM has no data yet so it never forwards.
  function automatic fwd_sel_e fwd_pick(input logic rd, input logic [1:0] r,
                                        input logic mem_wr, input logic mem_is_load,
                                        input logic [1:0] mem_dst,
                                        input logic wb_wr, input logic [1:0] wb_dst);
    if (!rd) begin
      return SEL_RF;
    end else if (mem_wr && !mem_is_load && (mem_dst == r)) begin
      return SEL_EXMEM;
    end else if (wb_wr && (wb_dst == r)) begin
      return SEL_MEMWB;
    end else begin
      return SEL_RF;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipe-side signal bundle of the hazard controller; slave is the controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [7:0]       id_ins;
  logic             br_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (output id_ins, br_taken,
                  input  pc_en, ifid_en, ifid_flush, idex_bubble,
                         fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt);

  modport slave  (input  id_ins, br_taken,
                  output pc_en, ifid_en, ifid_flush, idex_bubble,
                         fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt);
endinterface

// File: rtl/pipe_hazard_ctrl_dec.sv
// ins_class_dec: classifies one instruction byte as RF writer / ra reader / rb reader.
module ins_class_dec
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [7:0] ins,
  output logic       wr_en,
  output logic [1:0] wr_reg,
  output logic       rd_a,
  output logic       rd_b
);

  logic unused_rb_s;

  assign wr_reg      = ra_of(ins);
  assign unused_rb_s = ^rb_of(ins);

  // Opcode class table.
  always_comb begin
    wr_en = 1'b0;
    rd_a  = 1'b0;
    rd_b  = 1'b0;
    case (op_of(ins))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        wr_en = 1'b1;
        rd_a  = 1'b1;
        rd_b  = 1'b1;
      end
      OP_OUT: begin
        rd_a  = 1'b1;
      end
      OP_IN, OP_LOAD, OP_LOADIMM: begin
        wr_en = 1'b1;
      end
      OP_MOV: begin
        wr_en = 1'b1;
        rd_b  = 1'b1;
      end
      OP_STORE: begin
        rd_a  = 1'b1;
        rd_b  = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
        rd_a  = 1'b0;
        rd_b  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the SimpleCPU 5-stage pipe.
// Build option FORWARDING_EN enables EX operand forwarding; without it RAW hazards stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [7:0] NOP_INS = ISA_NOP,
  parameter int         CNT_W   = 16
)(
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       ex_r, mem_r, wb_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Index 0 = ID, 1 = EX, 2 = MEM, 3 = WB.
  logic [3:0][7:0]  ins_s;
  logic [3:0]       wr_en_s, rd_a_s, rd_b_s;
  logic [3:0][1:0]  wr_reg_s;
  logic             hazard_s, stall_s, bubble_s, unused_dec_s;
  fwd_sel_e         fwd_a_s, fwd_b_s;

  assign ins_s = {wb_r, mem_r, ex_r, bus.id_ins};

  for (genvar g = 0; g < 4; g++) begin : g_dec
    ins_class_dec u_dec (
      .ins    (ins_s[g]),
      .wr_en  (wr_en_s[g]),
      .wr_reg (wr_reg_s[g]),
      .rd_a   (rd_a_s[g]),
      .rd_b   (rd_b_s[g])
    );
  end

  assign unused_dec_s = ^{wr_en_s, rd_a_s, rd_b_s, wr_reg_s[0]};

`ifdef FORWARDING_EN
  assign hazard_s = (op_of(ex_r) == OP_LOAD) &&
                    uses_reg(rd_a_s[0], rd_b_s[0], bus.id_ins, wr_reg_s[1]);

  // Operand selects come only from the registered shadows.
  always_comb begin
    fwd_a_s = fwd_pick(rd_a_s[1], ra_of(ex_r), wr_en_s[2], op_of(mem_r) == OP_LOAD,
                       wr_reg_s[2], wr_en_s[3], wr_reg_s[3]);
    fwd_b_s = fwd_pick(rd_b_s[1], rb_of(ex_r), wr_en_s[2], op_of(mem_r) == OP_LOAD,
                       wr_reg_s[2], wr_en_s[3], wr_reg_s[3]);
  end
`else
  // No write-through in the RF, so any in-flight producer blocks the reader.
  assign hazard_s = (wr_en_s[1] && uses_reg(rd_a_s[0], rd_b_s[0], bus.id_ins, wr_reg_s[1])) ||
                    (wr_en_s[2] && uses_reg(rd_a_s[0], rd_b_s[0], bus.id_ins, wr_reg_s[2])) ||
                    (wr_en_s[3] && uses_reg(rd_a_s[0], rd_b_s[0], bus.id_ins, wr_reg_s[3]));
  assign fwd_a_s  = SEL_RF;
  assign fwd_b_s  = SEL_RF;
`endif

  // A taken branch squashes the stalled instruction anyway, so it wins.
  assign stall_s  = hazard_s & ~bus.br_taken;
  assign bubble_s = stall_s | bus.br_taken;

  assign bus.pc_en       = ~stall_s;
  assign bus.ifid_en     = ~stall_s;
  assign bus.ifid_flush  = bus.br_taken;
  assign bus.idex_bubble = bubble_s;
  assign bus.fwd_a_sel   = fwd_a_s;
  assign bus.fwd_b_sel   = fwd_b_s;
  assign bus.stall_cnt   = stall_cnt_r;
  assign bus.flush_cnt   = flush_cnt_r;

  // Shadow registers track EX/MEM/WB contents; the pipe never freezes past ID.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_r  <= NOP_INS;
      mem_r <= NOP_INS;
      wb_r  <= NOP_INS;
    end else begin
      ex_r  <= bubble_s ? NOP_INS : bus.id_ins;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.br_taken && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed ISA scenarios plus random traffic
// against an instruction-level pipe model; follows the FORWARDING_EN setting of the build.
module tb_pipe_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  pipe_hazard_ctrl #(.NOP_INS(8'h00), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus16));
  pipe_hazard_ctrl #(.NOP_INS(8'h00), .CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Model: what sits in EX, MEM, WB, and unbounded event counts.
  logic [7:0] m_pipe [3];
  int         m_stalls;
  int         m_flushes;

  function automatic bit m_writes(input logic [7:0] i);
    return i[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hD, 4'hF};
  endfunction

  function automatic bit m_reads_a(input logic [7:0] i);
    return i[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE};
  endfunction

  function automatic bit m_reads_b(input logic [7:0] i);
    return i[7:4] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hE};
  endfunction

  function automatic bit m_uses(input logic [7:0] i, input logic [1:0] r);
    return (m_reads_a(i) && i[3:2] == r) || (m_reads_b(i) && i[1:0] == r);
  endfunction

  function automatic bit m_hazard(input logic [7:0] id);
    if (FWD) return (m_pipe[0][7:4] == 4'hD) && m_uses(id, m_pipe[0][3:2]);
    for (int k = 0; k < 3; k++)
      if (m_writes(m_pipe[k]) && m_uses(id, m_pipe[k][3:2])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_sel(input bit is_b);
    bit         rd;
    logic [1:0] r;
    if (!FWD) return 2'b00;
    rd = is_b ? m_reads_b(m_pipe[0]) : m_reads_a(m_pipe[0]);
    r  = is_b ? m_pipe[0][1:0] : m_pipe[0][3:2];
    if (!rd) return 2'b00;
    if (m_writes(m_pipe[1]) && m_pipe[1][7:4] != 4'hD && m_pipe[1][3:2] == r) return 2'b01;
    if (m_writes(m_pipe[2]) && m_pipe[2][3:2] == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = 8'h00;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // One cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic [7:0] ins, input logic br, input logic r, output bit stalled);
    bit st;
    bus16.id_ins = ins;  bus2.id_ins = ins;
    bus16.br_taken = br; bus2.br_taken = br;
    rst = r;
    #1;
    st = m_hazard(ins) && !br;
    chk("pc_en",       32'(bus16.pc_en),       32'(!st));
    chk("ifid_en",     32'(bus16.ifid_en),     32'(!st));
    chk("ifid_flush",  32'(bus16.ifid_flush),  32'(br));
    chk("idex_bubble", 32'(bus16.idex_bubble), 32'(st || br));
    chk("fwd_a_sel",   32'(bus16.fwd_a_sel),   32'(m_sel(1'b0)));
    chk("fwd_b_sel",   32'(bus16.fwd_b_sel),   32'(m_sel(1'b1)));
    chk("stall_cnt",   32'(bus16.stall_cnt),   sat(m_stalls, 16));
    chk("flush_cnt",   32'(bus16.flush_cnt),   sat(m_flushes, 16));
    chk("stall_cnt_w2", 32'(bus2.stall_cnt),   sat(m_stalls, 2));
    chk("flush_cnt_w2", 32'(bus2.flush_cnt),   sat(m_flushes, 2));
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (st || br) ? 8'h00 : ins;
      m_stalls  += int'(st);
      m_flushes += int'(br);
    end
    stalled = st;
    @(negedge clk);
  endtask

  // Present an instruction in ID until it is accepted into EX.
  task automatic issue(input logic [7:0] ins, output int n_stall);
    bit st;
    n_stall = 0;
    for (int n = 0; n < 6; n++) begin
      step(ins, 1'b0, 1'b1, st);
      if (!st) return;
      n_stall++;
    end
    tests++;
    failed++;
    $error("FAIL issue_bound observed=%0d stall cycles expected=at most 5", n_stall);
  endtask

  initial begin
    int        ns;
    bit        st;
    int        s_before, f_before;
    logic [7:0] rins;
    logic      rbr, rrst;

    bus16.id_ins = 8'h00; bus2.id_ins = 8'h00;
    bus16.br_taken = 1'b0; bus2.br_taken = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_pc_en",      32'(bus16.pc_en),       32'd1);
    chk("rst_ifid_en",    32'(bus16.ifid_en),     32'd1);
    chk("rst_ifid_flush", 32'(bus16.ifid_flush),  32'd0);
    chk("rst_bubble",     32'(bus16.idex_bubble), 32'd0);
    chk("rst_fwd_a",      32'(bus16.fwd_a_sel),   32'd0);
    chk("rst_fwd_b",      32'(bus16.fwd_b_sel),   32'd0);
    chk("rst_stall_cnt",  32'(bus16.stall_cnt),   32'd0);
    chk("rst_flush_cnt",  32'(bus16.flush_cnt),   32'd0);
    @(negedge clk);

    // Load-use: LOAD r1 then ADD r2,r1.
    issue(8'hD4, ns);
    issue(8'h19, ns);
    chk("lu_stall_cycles", ns, FWD ? 1 : 3);
    chk("lu_fwd_b", 32'(bus16.fwd_b_sel), FWD ? 32'd2 : 32'd0);
    chk("lu_stall_cnt", 32'(bus16.stall_cnt), FWD ? 32'd1 : 32'd3);

    // ALU chain: ADD r1,r0 ; ADD r2,r1 ; ADD r3,r1.
    issue(8'h14, ns);
    issue(8'h19, ns);
    chk("chain_stall_cycles", ns, FWD ? 0 : 3);
    chk("chain_fwd_b_mem", 32'(bus16.fwd_b_sel), FWD ? 32'd1 : 32'd0);
    issue(8'h1D, ns);
    chk("chain_fwd_b_wb", 32'(bus16.fwd_b_sel), FWD ? 32'd2 : 32'd0);
    chk("chain_fwd_a", 32'(bus16.fwd_a_sel), 32'd0);

    // Taken branch on top of a load-use hazard.
    issue(8'hD4, ns);
    s_before = m_stalls;
    f_before = m_flushes;
    step(8'h19, 1'b1, 1'b1, st);
    chk("br_stall_hold", 32'(bus16.stall_cnt), s_before);
    chk("br_flush_inc",  32'(bus16.flush_cnt), f_before + 1);

    // Reset while stalling drops the stall at that edge.
    issue(8'hD4, ns);
    step(8'h19, 1'b0, 1'b0, st);
    chk("midrst_was_stall", 32'(st), 32'd1);
    step(8'h19, 1'b0, 1'b1, st);
    chk("midrst_no_stall", 32'(st), 32'd0);

    // Five load-use stalls saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      issue(8'hD4, ns);
      issue(8'h19, ns);
    end
    chk("sat_stall_w2", 32'(bus2.stall_cnt), 32'd3);
    chk("sat_stall_w16", 32'(bus16.stall_cnt), FWD ? 32'd5 : 32'd15);

    // Random traffic with occasional branches and resets.
    for (int i = 0; i < 400; i++) begin
      rins = 8'($urandom);
      rbr  = ($urandom_range(0, 5) == 0);
      rrst = ($urandom_range(0, 63) != 0);
      step(rins, rbr, rrst, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
